// File: rtl/parking_timer_ctrl_pkg.sv
// Shared definitions for the parking duration controller.
// Holds the mm:ss field width and limits, and the controller state encoding.
package sps_pkg;
  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;
  localparam logic [TIME_W-1:0] MAX_MIN = 6'd59;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;
endpackage

// File: rtl/parking_timer_ctrl_if.sv
// Bundle between the parking FSM / display and the duration controller.
// master: drives tick_1hz, spots, exit_signal, exit_slot; reads the display outputs.
// slave : the controller; reads the inputs, drives mode, minutes, seconds, busy.
interface parking_timer_ctrl_if;
  import sps_pkg::*;

  logic              tick_1hz;
  logic [3:0]        spots;
  logic              exit_signal;
  logic [1:0]        exit_slot;
  logic              mode;
  logic [TIME_W-1:0] minutes;
  logic [TIME_W-1:0] seconds;
  logic              busy;

  modport master (
    output tick_1hz, spots, exit_signal, exit_slot,
    input  mode, minutes, seconds, busy
  );

  modport slave (
    input  tick_1hz, spots, exit_signal, exit_slot,
    output mode, minutes, seconds, busy
  );
endinterface

// File: rtl/parking_timer_ctrl_spot_timer.sv
// Per-spot occupancy timer: rise detection on occupied, saturating mm:ss count.
// Ports: clk, reset (async active-low), tick_1hz, occupied, clr_valid in;
//        min, sec (mm:ss), valid (a car arrived and has not been reported) out.
module spot_timer
  import sps_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              occupied,
  input  logic              clr_valid,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              valid
);
  logic              occ_q;
  logic              valid_q, valid_d;
  logic [TIME_W-1:0] sec_q, sec_d;
  logic [TIME_W-1:0] min_q, min_d;
  logic              rise;
  logic              at_max;

  assign rise   = occupied & ~occ_q;
  assign at_max = (sec_q == MAX_SEC) && (min_q == MAX_MIN);

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    valid_d = valid_q;
    // A new arrival clears the timer even if a tick lands in the same cycle.
    if (rise) begin
      sec_d   = '0;
      min_d   = '0;
      valid_d = 1'b1;
    end else begin
      if (tick_1hz && occupied && !at_max) begin
        if (sec_q == MAX_SEC) begin
          sec_d = '0;
          min_d = min_q + 6'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
      if (clr_valid) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occupied;
      sec_q   <= sec_d;
      min_q   <= min_d;
      valid_q <= valid_d;
    end
  end

  assign min   = min_q;
  assign sec   = sec_q;
  assign valid = valid_q;
endmodule

// File: rtl/parking_timer_ctrl.sv
// Parking duration controller: four spot timers, exit edge detection, and a
// two-state display FSM that shows the exiting car's mm:ss for HOLD_SEC ticks.
// Ports: clk, reset (async active-low), bus (slave modport: tick_1hz, spots,
//        exit_signal, exit_slot in; mode, minutes, seconds, busy out).
//
// state | meaning
// IDLE  | display shows capacity (mode=0, busy=0)
// SHOW  | display shows latched exit time, hold_cnt counts ticks down
module parking_timer_ctrl
  import sps_pkg::*;
#(
  parameter int HOLD_SEC  = 5,
  parameter int NUM_SPOTS = 4
) (
  input  logic               clk,
  input  logic               reset,
  parking_timer_ctrl_if.slave bus
);
  localparam logic [TIME_W-1:0] HOLD_LOAD = TIME_W'(HOLD_SEC);

  logic [TIME_W-1:0] spot_min [NUM_SPOTS];
  logic [TIME_W-1:0] spot_sec [NUM_SPOTS];
  logic [NUM_SPOTS-1:0] spot_valid;
  logic [NUM_SPOTS-1:0] clr_valid;

  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
    spot_timer u_spot_timer (
      .clk       (clk),
      .reset     (reset),
      .tick_1hz  (bus.tick_1hz),
      .occupied  (bus.spots[i]),
      .clr_valid (clr_valid[i]),
      .min       (spot_min[i]),
      .sec       (spot_sec[i]),
      .valid     (spot_valid[i])
    );
  end

  state_e            state_q, state_d;
  logic [TIME_W-1:0] hold_q, hold_d;
  logic [TIME_W-1:0] minutes_q, minutes_d;
  logic [TIME_W-1:0] seconds_q, seconds_d;
  logic              mode_q, busy_q;
  logic              exit_q;
  logic              exit_evt;

  // Only a rising edge on a spot with an unreported arrival counts as an exit.
  assign exit_evt = bus.exit_signal & ~exit_q & spot_valid[bus.exit_slot];

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    clr_valid = '0;
    // Exit takes priority over the tick decrement; the spot registers still
    // hold the pre-increment value this cycle.
    if (exit_evt) begin
      minutes_d              = spot_min[bus.exit_slot];
      seconds_d              = spot_sec[bus.exit_slot];
      clr_valid[bus.exit_slot] = 1'b1;
      hold_d                 = HOLD_LOAD;
      state_d                = SHOW;
    end else if (state_q == SHOW && bus.tick_1hz) begin
      hold_d = hold_q - 6'd1;
      if (hold_q == 6'd1) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      exit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      mode_q    <= (state_d == SHOW);
      busy_q    <= (state_d == SHOW);
      exit_q    <= bus.exit_signal;
    end
  end

  assign bus.mode    = mode_q;
  assign bus.busy    = busy_q;
  assign bus.minutes = minutes_q;
  assign bus.seconds = seconds_q;
endmodule

// File: tb/tb_parking_timer_ctrl.sv
// Directed bench for parking_timer_ctrl with HOLD_SEC = 5.
module tb_parking_timer_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  parking_timer_ctrl_if bus_if ();

  parking_timer_ctrl #(.HOLD_SEC(5), .NUM_SPOTS(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One tick cycle followed by one quiet cycle; returns on a negedge.
  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      bus_if.tick_1hz = 1'b1;
      @(negedge clk);
      bus_if.tick_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic exit_hi(input logic [1:0] slot, input logic tk);
    bus_if.exit_signal = 1'b1;
    bus_if.exit_slot   = slot;
    bus_if.tick_1hz    = tk;
    @(negedge clk);
    bus_if.tick_1hz    = 1'b0;
  endtask

  task automatic exit_lo();
    bus_if.exit_signal = 1'b0;
    bus_if.exit_slot   = 2'd0;
    @(negedge clk);
  endtask

  task automatic set_spots(input logic [3:0] v);
    bus_if.spots = v;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic m, input int mi, input int se);
    chk({tag, ".mode"},    32'(bus_if.mode), 32'(m));
    chk({tag, ".busy"},    32'(bus_if.busy), 32'(m));
    chk({tag, ".minutes"}, 32'(bus_if.minutes), 32'(mi));
    chk({tag, ".seconds"}, 32'(bus_if.seconds), 32'(se));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.tick_1hz    = 1'b0;
    bus_if.spots       = 4'b0000;
    bus_if.exit_signal = 1'b0;
    bus_if.exit_slot   = 2'd0;
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Spot 2: 75 s -> 01:15, held for exactly 5 ticks.
    set_spots(4'b0100);
    do_ticks(75);
    set_spots(4'b0000);
    exit_hi(2'd2, 1'b0);
    chk_out("exit2", 1'b1, 1, 15);
    exit_lo();
    do_ticks(4);
    chk("hold2_4ticks.mode", 32'(bus_if.mode), 32'd1);
    do_ticks(1);
    chk_out("hold2_done", 1'b0, 1, 15);

    // Re-exit on an already reported spot and exit on a never-used spot.
    exit_hi(2'd2, 1'b0);
    chk_out("reexit2", 1'b0, 1, 15);
    exit_lo();
    exit_hi(2'd3, 1'b0);
    chk_out("exit3_empty", 1'b0, 1, 15);
    exit_lo();

    // Preempt: spot1 = 00:30 exits, after 3 ticks spot3 (00:23) exits.
    set_spots(4'b0010);
    do_ticks(10);
    set_spots(4'b1010);
    do_ticks(20);
    set_spots(4'b1000);
    exit_hi(2'd1, 1'b0);
    chk_out("exit1", 1'b1, 0, 30);
    exit_lo();
    do_ticks(3);
    chk("show_3ticks.mode", 32'(bus_if.mode), 32'd1);
    exit_hi(2'd3, 1'b0);
    chk_out("preempt3", 1'b1, 0, 23);
    exit_lo();
    do_ticks(4);
    chk("preempt_4ticks.mode", 32'(bus_if.mode), 32'd1);
    do_ticks(1);
    chk_out("preempt_done", 1'b0, 0, 23);

    // Exit coincident with tick at 00:09: pre-increment value, full reload.
    set_spots(4'b1001);
    do_ticks(9);
    exit_hi(2'd0, 1'b1);
    chk_out("coinc0", 1'b1, 0, 9);
    exit_lo();
    do_ticks(4);
    chk("coinc_4ticks.mode", 32'(bus_if.mode), 32'd1);
    do_ticks(1);
    chk("coinc_done.mode", 32'(bus_if.mode), 32'd0);

    // Reset in the middle of SHOW.
    set_spots(4'b0010);
    do_ticks(2);
    exit_hi(2'd1, 1'b0);
    chk_out("exit1_pre_rst", 1'b1, 0, 2);
    exit_lo();
    #2;
    rst_n        = 1'b0;
    bus_if.spots = 4'b0000;
    @(negedge clk);
    chk_out("mid_show_rst", 1'b0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exit_hi(2'd1, 1'b0);
    chk_out("post_rst_exit1", 1'b0, 0, 0);
    exit_lo();

    // Saturation at 59:59.
    set_spots(4'b0001);
    do_ticks(3605);
    set_spots(4'b0000);
    exit_hi(2'd0, 1'b0);
    chk_out("sat0", 1'b1, 59, 59);
    exit_lo();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
